async_fifo_reader: RTL and testbench
====================================

# async_fifo_reader

Read-side companion of `async_fifo`. It runs in the read clock domain, drives the FIFO's `I_rden` and captures `O_data_out`, and re-times the result as a valid/ready stream. A 4-entry skid buffer hides the one-cycle FIFO read latency, so an always-ready sink receives one word per cycle. The block adds `O_last` framing every `BURST_LEN` beats and a synchronous flush.

## Interface
Parameters:
- `DATAWIDTH`, 8, word width; must match the FIFO.
- `BURST_LEN`, 8, beats per frame; legal range 1..255. `O_last` marks the final beat of each frame.

Ports:
- `clk_rd`  in  1  read-domain clock, the same clock as the FIFO read port.
- `rrst_n`  in  1  reset; asynchronous, active-low.
- `I_empty`  in  1  FIFO `empty`.
- `O_rden`  out  1  FIFO read enable (combinational).
- `I_fifo_data`  in  DATAWIDTH  FIFO `O_data_out`.
- `O_data`  out  DATAWIDTH  stream data; equals the buffer head.
- `O_valid`  out  1  stream valid.
- `I_ready`  in  1  stream ready.
- `O_last`  out  1  the current beat is the last beat of a frame.
- `I_flush`  in  1  synchronous flush pulse.
- `O_beat_cnt`  out  16  accepted-beat counter; see Configuration.

## Operation
- **FIFO read model:**
  - A read is issued in cycle k when `O_rden`=1 and `I_empty`=0.
  - The word is valid on `I_fifo_data` in cycle k+1, and the block captures it at the end of k+1.
- **Occupancy:**
  - `occ` = buffered words (0..4) + read in flight (0/1). It is a registered 3-bit value, range 0..4.
- **Read issue:**
  - `O_rden = !I_empty && !I_flush && occ < 4`.
  - `occ` is registered, so `O_rden` has no combinational path from `I_ready`.
- **Buffer:**
  - 4-entry circular buffer with 2-bit write and read pointers that wrap 3→0.
  - Capture writes at the write pointer. A pop (`O_valid && I_ready`) advances the read pointer.
  - A capture and a pop in the same cycle are legal at any fill level. The `occ` rule makes overflow impossible.
- **Output:**
  - `O_valid` = buffer non-empty.
  - `O_data` = buffer head.
  - Once asserted, `O_valid` and `O_data` hold until accepted.
- **Framing:**
  - 8-bit `beat_idx` counts accepted beats 0..`BURST_LEN`-1 and wraps to 0 after the accept where it equals `BURST_LEN`-1.
  - `O_last = O_valid && beat_idx == BURST_LEN-1`. With `BURST_LEN`=1, every beat is last.
- **Flush (`I_flush`=1, one cycle):**
  - Clears the buffer, both pointers and `beat_idx`.
  - Forces `O_rden`=0.
  - Marks any in-flight read as discard: its data arriving next cycle is dropped, not captured.
  - A pop presented in the same cycle is still counted by `O_beat_cnt`, but the buffer ends empty.
  - `O_valid` is 0 from the next cycle.
- **Empty FIFO:**
  - No read is issued, and `O_valid` falls once the buffer drains.
  - There is no underrun error, because `O_rden` is gated by `I_empty`.

## Timing
- **Reset values:**
  - `O_valid`=0, `O_last`=0, `O_data`=0, `O_beat_cnt`=0.
  - `O_rden` = 0 while `rrst_n`=0.
  - `occ`=0, pointers 0, `beat_idx`=0, in-flight flag 0.
- **Reset mid-operation:** everything clears immediately, and in-flight and buffered words are lost. The FIFO has its own reset.
- **Latency:**
  - `I_empty` falls in cycle n, the read is issued in n, the word is captured at the end of n+1, and `O_valid`=1 in n+2.
  - Two cycles from FIFO not-empty to stream valid.
- **Throughput:** one beat per cycle sustained while the FIFO is non-empty and `I_ready`=1.
- **Backpressure:** when `I_ready`=0 the block stops issuing reads once `occ`=4, i.e. at most 4 words are pulled from the FIFO.

## Configuration
- Macro: `ASYNC_FIFO_READER_STATS_EN`.
- **Defined:**
  - `O_beat_cnt` is a 16-bit counter of accepted beats.
  - It increments on every pop, saturates at 16'hFFFF, and is not cleared by `I_flush`.
  - It is cleared only by `rrst_n`.
- **Undefined:** `O_beat_cnt` is tied to 0 and the counter logic is absent.

## Test plan
- **Latency:**
  - Stimulus: FIFO pre-loaded with 0x7E; `I_empty` falls in cycle 10; `I_ready`=1.
  - Required: `O_rden`=1 in cycle 10; `O_valid`=1 with `O_data`=0x7E in cycle 12; `O_valid`=0 in cycle 13.
- **Streaming:**
  - Stimulus: FIFO holds 0x00..0x0F; `I_ready`=1; `BURST_LEN`=8.
  - Required: 16 consecutive beats with no gaps; `O_last` on beats 0x07 and 0x0F; `O_beat_cnt`=16 when the macro is defined.
- **Backpressure:**
  - Stimulus: FIFO holds 10 words; `I_ready`=0 for 20 cycles.
  - Required: exactly 4 reads issued; `O_valid` stays 1 with `O_data` held at word 0.
  - Then with `I_ready`=1: all 10 words in order, with none lost or duplicated.
- **Flush:**
  - Stimulus: 3 words buffered, 1 in flight; pulse `I_flush`.
  - Required: next cycle `O_valid`=0 and the in-flight word is dropped; the next word delivered is FIFO word 5; `beat_idx` restarts at 0.
- **Reset:**
  - Stimulus: assert `rrst_n`=0 asynchronously mid-stream.
  - Required: `O_valid`, `O_rden` and `O_last` are 0 within the same cycle; after release the block resumes from empty.
- **Random traffic:**
  - Stimulus: random `I_ready` (50%) and random FIFO fill over 1000 words.
  - Required: output order matches input; `occ` never exceeds 4; `O_beat_cnt`=1000.

Source files
------------

// File: rtl/async_fifo_reader.sv
// async_fifo_reader
//   Read-side companion of async_fifo, clocked by the FIFO read clock. It drives
//   the FIFO read enable, captures the word one cycle later into a 4-entry skid
//   buffer, and presents the buffer head as a valid/ready stream with O_last
//   framing every BURST_LEN accepted beats.
//
//   Optional feature macro: ASYNC_FIFO_READER_STATS_EN
//     defined   : O_beat_cnt counts accepted beats (saturating, reset-only clear)
//     undefined : O_beat_cnt is tied to 0
//
// Ports
//   clk_rd      in   read-domain clock
//   rrst_n      in   asynchronous active-low reset
//   I_empty     in   FIFO empty flag
//   O_rden      out  FIFO read enable (combinational)
//   I_fifo_data in   FIFO read data, valid the cycle after a read
//   O_data      out  stream data (buffer head)
//   O_valid     out  stream valid
//   I_ready     in   stream ready
//   O_last      out  final beat of a frame
//   I_flush     in   synchronous flush pulse
//   O_beat_cnt  out  accepted-beat counter (see macro above)
module async_fifo_reader #(
    parameter int DATAWIDTH = 8,
    parameter int BURST_LEN = 8
) (
    input  logic                 clk_rd,
    input  logic                 rrst_n,
    input  logic                 I_empty,
    output logic                 O_rden,
    input  logic [DATAWIDTH-1:0] I_fifo_data,
    output logic [DATAWIDTH-1:0] O_data,
    output logic                 O_valid,
    input  logic                 I_ready,
    output logic                 O_last,
    input  logic                 I_flush,
    output logic [15:0]          O_beat_cnt
);

    localparam int         DEPTH    = 4;
    localparam logic [7:0] LAST_IDX = 8'(BURST_LEN - 1);

    logic [DATAWIDTH-1:0] mem_q [DEPTH];
    logic [DATAWIDTH-1:0] mem_d [DEPTH];
    logic [1:0]           wptr_q, wptr_d;
    logic [1:0]           rptr_q, rptr_d;
    logic [2:0]           count_q, count_d;   // words held in the buffer
    logic [2:0]           occ_q, occ_d;       // buffered words + read in flight
    logic                 inflight_q, inflight_d;
    logic [7:0]           beat_idx_q, beat_idx_d;

    logic rd_issue;
    logic capture;
    logic pop;

    // Read issue depends only on registered occupancy, never on I_ready.
    // rrst_n gates it so no read is requested while the block is in reset.
    always_comb begin
        rd_issue = rrst_n && !I_empty && !I_flush && (occ_q < 3'd4);
        // A flush discards the word of a read issued last cycle.
        capture  = inflight_q && !I_flush;
        pop      = O_valid && I_ready;
    end

    assign O_rden  = rd_issue;
    assign O_valid = (count_q != 3'd0);
    assign O_data  = mem_q[rptr_q];
    assign O_last  = O_valid && (beat_idx_q == LAST_IDX);

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (capture) begin
            mem_d[wptr_q] = I_fifo_data;
        end

        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        beat_idx_d = beat_idx_q;

        if (I_flush) begin
            wptr_d     = '0;
            rptr_d     = '0;
            count_d    = '0;
            beat_idx_d = '0;
        end else begin
            if (capture) begin
                wptr_d = wptr_q + 2'd1;
            end
            if (pop) begin
                rptr_d     = rptr_q + 2'd1;
                beat_idx_d = (beat_idx_q == LAST_IDX) ? 8'd0 : beat_idx_q + 8'd1;
            end
            count_d = count_q + {2'b00, capture} - {2'b00, pop};
        end

        inflight_d = rd_issue;
        occ_d      = count_d + {2'b00, rd_issue};
    end

    always_ff @(posedge clk_rd or negedge rrst_n) begin
        if (!rrst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            occ_q      <= '0;
            inflight_q <= 1'b0;
            beat_idx_q <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            beat_idx_q <= beat_idx_d;
        end
    end

`ifdef ASYNC_FIFO_READER_STATS_EN
    logic [15:0] beat_cnt_q, beat_cnt_d;

    // Counts every accepted beat, including one accepted during a flush.
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (pop && (beat_cnt_q != 16'hFFFF)) begin
            beat_cnt_d = beat_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_rd or negedge rrst_n) begin
        if (!rrst_n) begin
            beat_cnt_q <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign O_beat_cnt = beat_cnt_q;
`else
    assign O_beat_cnt = '0;
`endif

endmodule

// File: tb/tb_async_fifo_reader.sv
module tb_async_fifo_reader;

    localparam int BL = 8;

    logic        clk_rd = 1'b0;
    logic        rrst_n = 1'b0;
    logic        I_empty = 1'b1;
    logic        O_rden;
    logic [7:0]  I_fifo_data = '0;
    logic [7:0]  O_data;
    logic        O_valid;
    logic        I_ready = 1'b0;
    logic        O_last;
    logic        I_flush = 1'b0;
    logic [15:0] O_beat_cnt;

    async_fifo_reader #(.DATAWIDTH(8), .BURST_LEN(BL)) dut (
        .clk_rd     (clk_rd),
        .rrst_n     (rrst_n),
        .I_empty    (I_empty),
        .O_rden     (O_rden),
        .I_fifo_data(I_fifo_data),
        .O_data     (O_data),
        .O_valid    (O_valid),
        .I_ready    (I_ready),
        .O_last     (O_last),
        .I_flush    (I_flush),
        .O_beat_cnt (O_beat_cnt)
    );

    always #5 clk_rd = ~clk_rd;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Source FIFO contents (stimulus) and the reference model of the reader:
    // words pulled but not yet delivered, the word currently in flight,
    // frame position and accepted-beat count.
    bit [7:0]    fifo_q[$];
    bit [7:0]    mbuf[$];
    bit          m_inflight;
    bit [7:0]    m_word;
    int          m_beat;
    int unsigned m_cnt;
    int          issued;
    int          cyc;
    bit [7:0]    delivered[$];
    bit          delivered_last[$];
    int          pop_cyc[$];

    task automatic model_reset();
        mbuf.delete();
        m_inflight = 1'b0;
        m_beat     = 0;
        m_cnt      = 0;
        issued     = 0;
        delivered.delete();
        delivered_last.delete();
        pop_cyc.delete();
    endtask

    function automatic logic [15:0] exp_cnt(input int unsigned n);
`ifdef ASYNC_FIFO_READER_STATS_EN
        return (n > 65535) ? 16'hFFFF : 16'(n);
`else
        return (n > 0) ? 16'h0 : 16'h0;
`endif
    endfunction

    // One clock cycle: called at posedge+1, returns at the next posedge+1.
    task automatic cycle(input bit rdy, input bit fl);
        bit exp_valid, exp_rden, exp_pop;
        I_ready     = rdy;
        I_flush     = fl;
        I_empty     = (fifo_q.size() == 0);
        I_fifo_data = m_inflight ? m_word : 8'($urandom);
        @(negedge clk_rd);
        exp_valid = (mbuf.size() > 0);
        exp_rden  = !I_empty && !fl && ((mbuf.size() + int'(m_inflight)) < 4);
        chk("rden", O_rden, exp_rden);
        chk("valid", O_valid, exp_valid);
        if (exp_valid) chk("data", O_data, mbuf[0]);
        chk("last", O_last, exp_valid && (m_beat == BL - 1));
        chk("beat_cnt", O_beat_cnt, exp_cnt(m_cnt));
        if (O_valid && rdy) begin
            delivered.push_back(O_data);
            delivered_last.push_back(O_last);
            pop_cyc.push_back(cyc);
        end
        exp_pop = exp_valid && rdy;
        if (exp_pop) m_cnt++;
        if (fl) begin
            mbuf.delete();
            m_beat = 0;
        end else begin
            if (exp_pop) begin
                void'(mbuf.pop_front());
                m_beat = (m_beat == BL - 1) ? 0 : m_beat + 1;
            end
            if (m_inflight) mbuf.push_back(m_word);
        end
        m_inflight = 1'b0;
        if (O_rden && !I_empty) begin
            m_word     = fifo_q.pop_front();
            m_inflight = 1'b1;
            issued++;
        end
        @(posedge clk_rd);
        #1;
        cyc++;
    endtask

    // Asserts reset away from the clock edge and checks outputs settle in
    // the same cycle; I_empty is held low to show O_rden is gated by reset.
    task automatic do_reset();
        I_ready = 1'b0;
        I_flush = 1'b0;
        I_empty = 1'b0;
        #3 rrst_n = 1'b0;
        #2;
        chk("rst_valid", O_valid, 1'b0);
        chk("rst_rden", O_rden, 1'b0);
        chk("rst_last", O_last, 1'b0);
        chk("rst_data", O_data, 8'h00);
        chk("rst_cnt", O_beat_cnt, 16'h0);
        @(posedge clk_rd);
        @(posedge clk_rd);
        #1 rrst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        bit       empty;
        bit [7:0] fdata;
        bit       exp_rden;
        bit       exp_valid;
        bit [7:0] exp_data;
    } vec_t;

    vec_t tbl[14];

    initial begin
        bit [7:0] nextw;
        int       errs;
        int       pushed;

        for (int i = 0; i < 14; i++) begin
            tbl[i] = '{empty: 1'b1, fdata: 8'h00, exp_rden: 1'b0, exp_valid: 1'b0, exp_data: 8'h00};
        end
        tbl[10].empty     = 1'b0;
        tbl[10].fdata     = 8'hA5;
        tbl[10].exp_rden  = 1'b1;
        tbl[11].fdata     = 8'h7E;
        tbl[12].fdata     = 8'h3C;
        tbl[12].exp_valid = 1'b1;
        tbl[12].exp_data  = 8'h7E;

        @(posedge clk_rd);
        #1;
        do_reset();

        // Latency: cycle index counts from reset release.
        for (int i = 0; i < 14; i++) begin
            I_empty     = tbl[i].empty;
            I_fifo_data = tbl[i].fdata;
            I_ready     = 1'b1;
            I_flush     = 1'b0;
            @(negedge clk_rd);
            chk($sformatf("tbl%0d_rden", i), O_rden, tbl[i].exp_rden);
            chk($sformatf("tbl%0d_valid", i), O_valid, tbl[i].exp_valid);
            if (tbl[i].exp_valid) chk($sformatf("tbl%0d_data", i), O_data, tbl[i].exp_data);
            chk($sformatf("tbl%0d_last", i), O_last, 1'b0);
            @(posedge clk_rd);
            #1;
        end

        // Streaming 0x00..0x0F with an always-ready sink.
        do_reset();
        for (int i = 0; i < 16; i++) fifo_q.push_back(8'(i));
        for (int n = 0; n < 100 && delivered.size() < 16; n++) cycle(1'b1, 1'b0);
        chk("stream_count", delivered.size(), 16);
        if (delivered.size() == 16) begin
            chk("stream_gapless", pop_cyc[15] - pop_cyc[0], 15);
            for (int i = 0; i < 16; i++) begin
                chk($sformatf("stream_data%0d", i), delivered[i], 8'(i));
                chk($sformatf("stream_last%0d", i), delivered_last[i], (i == 7) || (i == 15));
            end
        end
        chk("stream_cnt", O_beat_cnt, exp_cnt(16));

        // Reset mid-stream: buffered and in-flight words are lost.
        do_reset();
        for (int i = 0; i < 20; i++) fifo_q.push_back(8'(100 + i));
        for (int n = 0; n < 6; n++) cycle(1'b1, 1'b0);
        chk("pre_rst_valid", O_valid, 1'b1);
        nextw = fifo_q[0];
        do_reset();
        for (int n = 0; n < 50 && delivered.size() < 1; n++) cycle(1'b1, 1'b0);
        chk("post_rst_count", delivered.size(), 1);
        if (delivered.size() > 0) chk("post_rst_word", delivered[0], nextw);
        fifo_q.delete();

        // Backpressure: at most 4 words pulled, head held.
        do_reset();
        for (int i = 0; i < 10; i++) fifo_q.push_back(8'(8'h20 + i));
        for (int n = 0; n < 20; n++) cycle(1'b0, 1'b0);
        chk("bp_issued", issued, 4);
        chk("bp_valid", O_valid, 1'b1);
        chk("bp_data", O_data, 8'h20);
        for (int n = 0; n < 100 && delivered.size() < 10; n++) cycle(1'b1, 1'b0);
        chk("bp_count", delivered.size(), 10);
        errs = 0;
        foreach (delivered[i]) if (delivered[i] != 8'(8'h20 + i)) errs++;
        chk("bp_order_errs", errs, 0);

        // Flush with 3 buffered words and 1 in flight.
        do_reset();
        for (int i = 1; i <= 16; i++) fifo_q.push_back(8'(i));
        for (int n = 0; n < 4; n++) cycle(1'b0, 1'b0);
        chk("fl_pre_valid", O_valid, 1'b1);
        cycle(1'b0, 1'b1);
        chk("fl_valid", O_valid, 1'b0);
        for (int n = 0; n < 100 && delivered.size() < 8; n++) cycle(1'b1, 1'b0);
        chk("fl_count", delivered.size(), 8);
        if (delivered.size() == 8) begin
            chk("fl_first_word", delivered[0], 8'd5);
            chk("fl_last6", delivered_last[6], 1'b0);
            chk("fl_last7", delivered_last[7], 1'b1);
        end
        fifo_q.delete();

        // Random traffic: 1000 words, random fill and 50% ready.
        do_reset();
        pushed = 0;
        for (int n = 0; n < 30000 && delivered.size() < 1000; n++) begin
            if (pushed < 1000 && $urandom_range(0, 1) == 1) begin
                fifo_q.push_back(8'(pushed));
                pushed++;
            end
            cycle($urandom_range(0, 1) == 1, 1'b0);
            if ((issued - int'(delivered.size())) > 4)
                chk("rand_occ_bound", issued - int'(delivered.size()), 4);
        end
        chk("rand_count", delivered.size(), 1000);
        errs = 0;
        foreach (delivered[i]) if (delivered[i] != 8'(i)) errs++;
        chk("rand_order_errs", errs, 0);
        chk("rand_cnt", O_beat_cnt, exp_cnt(1000));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
